// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types for the dual-issue hazard/forwarding controller.
// Slot b is the older branch pipe, slot m is the younger memory pipe.
package fwd_hazard_ctrl_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned SEL_W  = 3;

    typedef enum logic [SEL_W-1:0] {
        SEL_NORMAL  = 3'b000,
        SEL_BR_EX   = 3'b001,
        SEL_MEM_EX  = 3'b010,
        SEL_BR_MEM  = 3'b011,
        SEL_MEM_MEM = 3'b100,
        SEL_BR_WB   = 3'b101,
        SEL_MEM_WB  = 3'b110
    } fwd_sel_e;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              is_load;
    } inflight_t;

    typedef enum logic {
        ST_RUN,
        ST_SPLIT
    } ctrl_state_e;

    // x0 is hardwired zero, so a record naming it is never a forwarding source.
    function automatic logic rec_match(inflight_t r, logic [REG_AW-1:0] src);
        return r.valid & r.we & (r.rd == src) & (src != '0) & (r.is_load | ~r.is_load);
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// Decode-stage bundle into the controller and issue/forwarding results out.
interface fwd_hazard_ctrl_if;
    import fwd_hazard_ctrl_pkg::*;

    logic              id_valid_b, id_valid_m;
    logic [REG_AW-1:0] id_rs1_b, id_rs2_b, id_rs1_m, id_rs2_m;
    logic [REG_AW-1:0] id_rd_b, id_rd_m;
    logic              id_we_b, id_we_m;
    logic              id_is_load_m;
    logic              flush;

    logic              issue_b, issue_m;
    logic              stall_fetch;
    logic [SEL_W-1:0]  fwd_sel_rs1_b, fwd_sel_rs2_b, fwd_sel_rs1_m, fwd_sel_rs2_m;

    modport master (
        output id_valid_b, id_valid_m, id_rs1_b, id_rs2_b, id_rs1_m, id_rs2_m,
               id_rd_b, id_rd_m, id_we_b, id_we_m, id_is_load_m, flush,
        input  issue_b, issue_m, stall_fetch,
               fwd_sel_rs1_b, fwd_sel_rs2_b, fwd_sel_rs1_m, fwd_sel_rs2_m
    );

    modport slave (
        input  id_valid_b, id_valid_m, id_rs1_b, id_rs2_b, id_rs1_m, id_rs2_m,
               id_rd_b, id_rd_m, id_we_b, id_we_m, id_is_load_m, flush,
        output issue_b, issue_m, stall_fetch,
               fwd_sel_rs1_b, fwd_sel_rs2_b, fwd_sel_rs1_m, fwd_sel_rs2_m
    );

endinterface

// File: rtl/fwd_hazard_ctrl_src_match.sv
// Compares one decode source against the six in-flight records and picks
// the youngest matching producer; also flags a hit on a load still in ID/EX.
module fwd_src_match
    import fwd_hazard_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  inflight_t         idex_b,
    input  inflight_t         idex_m,
    input  inflight_t         exmem_b,
    input  inflight_t         exmem_m,
    input  inflight_t         memwb_b,
    input  inflight_t         memwb_m,
    output fwd_sel_e          sel,
    output logic              load_hit
);

    always_comb begin
        sel = SEL_NORMAL;
        if (rec_match(idex_m, src))
            sel = SEL_MEM_EX;
        else if (rec_match(idex_b, src))
            sel = SEL_BR_EX;
        else if (rec_match(exmem_m, src))
            sel = SEL_MEM_MEM;
        else if (rec_match(exmem_b, src))
            sel = SEL_BR_MEM;
        else if (rec_match(memwb_m, src))
            sel = SEL_MEM_WB;
        else if (rec_match(memwb_b, src))
            sel = SEL_BR_WB;
    end

    assign load_hit = rec_match(idex_m, src) & idex_m.is_load;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Issue/hazard controller: shadow pipeline records, registered forwarding
// selects, load-use stall and intra-bundle split sequencing.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    fwd_hazard_ctrl_if.slave   dif
);

    ctrl_state_e state, state_nxt;
    inflight_t   idex_b, idex_m, exmem_b, exmem_m, memwb_b, memwb_m;

    logic [REG_AW-1:0] src      [4];
    fwd_sel_e          sel      [4];
    logic              load_hit [4];
    logic [SEL_W-1:0]  sel_q    [4];

    logic slot_b_live, load_use, intra;
    logic issue_b, issue_m, stall_fetch;

    assign src[0] = dif.id_rs1_b;
    assign src[1] = dif.id_rs2_b;
    assign src[2] = dif.id_rs1_m;
    assign src[3] = dif.id_rs2_m;

    for (genvar i = 0; i < 4; i++) begin : g_match
        fwd_src_match u_match (
            .src      (src[i]),
            .idex_b   (idex_b),
            .idex_m   (idex_m),
            .exmem_b  (exmem_b),
            .exmem_m  (exmem_m),
            .memwb_b  (memwb_b),
            .memwb_m  (memwb_m),
            .sel      (sel[i]),
            .load_hit (load_hit[i])
        );
    end

    // In SPLIT the branch slot already left, so it is masked from hazard checks.
    assign slot_b_live = dif.id_valid_b & (state == ST_RUN);
    assign load_use    = (slot_b_live & (load_hit[0] | load_hit[1]))
                       | (dif.id_valid_m & (load_hit[2] | load_hit[3]));
    assign intra       = slot_b_live & dif.id_valid_m & dif.id_we_b & (dif.id_rd_b != '0)
                       & ((dif.id_rs1_m == dif.id_rd_b) | (dif.id_rs2_m == dif.id_rd_b));

    always_comb begin
        state_nxt   = state;
        issue_b     = 1'b0;
        issue_m     = 1'b0;
        stall_fetch = 1'b0;
        if (dif.flush) begin
            state_nxt = ST_RUN;
        end else if (load_use) begin
            stall_fetch = 1'b1;
        end else if (state == ST_RUN) begin
            if (intra) begin
                issue_b     = 1'b1;
                stall_fetch = 1'b1;
                state_nxt   = ST_SPLIT;
            end else begin
                issue_b = dif.id_valid_b;
                issue_m = dif.id_valid_m;
            end
        end else begin
            issue_m   = dif.id_valid_m;
            state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            idex_b  <= '0;
            idex_m  <= '0;
            exmem_b <= '0;
            exmem_m <= '0;
            memwb_b <= '0;
            memwb_m <= '0;
            for (int unsigned i = 0; i < 4; i++)
                sel_q[i] <= '0;
        end else begin
            state   <= state_nxt;
            memwb_b <= exmem_b;
            memwb_m <= exmem_m;
            exmem_b <= idex_b;
            exmem_m <= idex_m;
            if (issue_b)
                idex_b <= '{valid: 1'b1, rd: dif.id_rd_b, we: dif.id_we_b, is_load: 1'b0};
            else
                idex_b <= '0;
            if (issue_m)
                idex_m <= '{valid: 1'b1, rd: dif.id_rd_m, we: dif.id_we_m, is_load: dif.id_is_load_m};
            else
                idex_m <= '0;
            sel_q[0] <= issue_b ? sel[0] : SEL_NORMAL;
            sel_q[1] <= issue_b ? sel[1] : SEL_NORMAL;
            sel_q[2] <= issue_m ? sel[2] : SEL_NORMAL;
            sel_q[3] <= issue_m ? sel[3] : SEL_NORMAL;
        end
    end

    assign dif.issue_b       = issue_b;
    assign dif.issue_m       = issue_m;
    assign dif.stall_fetch   = stall_fetch;
    assign dif.fwd_sel_rs1_b = sel_q[0];
    assign dif.fwd_sel_rs2_b = sel_q[1];
    assign dif.fwd_sel_rs1_m = sel_q[2];
    assign dif.fwd_sel_rs2_m = sel_q[3];

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: per-cycle bundles with hand-derived
// issue/stall expectations and queued registered-select expectations.
module tb_fwd_hazard_ctrl;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    fwd_hazard_ctrl_if dif();

    fwd_hazard_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dif   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vb;
        logic [4:0] rs1b, rs2b, rdb;
        logic       web;
        logic       vm;
        logic [4:0] rs1m, rs2m, rdm;
        logic       wem, ldm;
        logic       fl;
        logic [2:0] ctl;   // {issue_b, issue_m, stall_fetch}
        logic [11:0] sel;  // {rs1_b, rs2_b, rs1_m, rs2_m}
    } vec_t;

    logic [11:0] sb [$];
    logic [11:0] exp_sel;

    function automatic logic [11:0] s4(int a, int b, int c, int d);
        return {a[2:0], b[2:0], c[2:0], d[2:0]};
    endfunction

    function automatic vec_t mk(int vb, int rs1b, int rs2b, int rdb, int web,
                                int vm, int rs1m, int rs2m, int rdm, int wem, int ldm,
                                int fl, logic [2:0] ctl, logic [11:0] sel);
        vec_t v;
        v.vb = vb[0];   v.rs1b = rs1b[4:0]; v.rs2b = rs2b[4:0]; v.rdb = rdb[4:0]; v.web = web[0];
        v.vm = vm[0];   v.rs1m = rs1m[4:0]; v.rs2m = rs2m[4:0]; v.rdm = rdm[4:0];
        v.wem = wem[0]; v.ldm = ldm[0];     v.fl = fl[0];
        v.ctl = ctl;    v.sel = sel;
        return v;
    endfunction

    function automatic logic [2:0] ctl_now();
        return {dif.issue_b, dif.issue_m, dif.stall_fetch};
    endfunction

    function automatic logic [11:0] dut_sel();
        return {dif.fwd_sel_rs1_b, dif.fwd_sel_rs2_b, dif.fwd_sel_rs1_m, dif.fwd_sel_rs2_m};
    endfunction

    task automatic apply(input vec_t v);
        dif.id_valid_b   = v.vb;
        dif.id_rs1_b     = v.rs1b;
        dif.id_rs2_b     = v.rs2b;
        dif.id_rd_b      = v.rdb;
        dif.id_we_b      = v.web;
        dif.id_valid_m   = v.vm;
        dif.id_rs1_m     = v.rs1m;
        dif.id_rs2_m     = v.rs2m;
        dif.id_rd_m      = v.rdm;
        dif.id_we_m      = v.wem;
        dif.id_is_load_m = v.ldm;
        dif.flush        = v.fl;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        apply(mk(0,0,0,0,0, 0,0,0,0,0,0, 0, 3'b000, '0));
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_sel() !== 12'h000) begin
            errors++; $display("FAIL reset_sel got %h exp %h", dut_sel(), 12'h000);
        end
        apply(mk(1,1,2,0,0, 1,3,4,0,0,0, 0, 3'b110, '0));
        #1;
        checks++;
        if (ctl_now() !== 3'b110) begin
            errors++; $display("FAIL reset_ctl got %b exp %b", ctl_now(), 3'b110);
        end
        apply(mk(0,0,0,0,0, 0,0,0,0,0,0, 0, 3'b000, '0));
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fwd_distance();
        vec_t v[$];
        v.push_back(mk(1,1,2,5,1,   0,0,0,0,0,0,  0, 3'b100, s4(0,0,0,0)));
        v.push_back(mk(1,5,6,10,0,  0,0,0,0,0,0,  0, 3'b100, s4(1,0,0,0)));
        v.push_back(mk(1,5,6,10,0,  1,5,0,11,0,0, 0, 3'b110, s4(3,0,3,0)));
        v.push_back(mk(1,0,5,10,0,  0,0,0,0,0,0,  0, 3'b100, s4(0,5,0,0)));
        v.push_back(mk(1,5,5,10,0,  0,0,0,0,0,0,  0, 3'b100, s4(0,0,0,0)));
        foreach (v[i]) begin
            apply(v[i]); #1;
            checks++;
            if (ctl_now() !== v[i].ctl) begin
                errors++; $display("FAIL fwd_distance[%0d] ctl got %b exp %b", i, ctl_now(), v[i].ctl);
            end
            sb.push_back(v[i].sel);
            @(posedge clk); #1;
            exp_sel = sb.pop_front();
            checks++;
            if (dut_sel() !== exp_sel) begin
                errors++; $display("FAIL fwd_distance[%0d] sel got %h exp %h", i, dut_sel(), exp_sel);
            end
        end
    endtask

    task automatic test_load_use();
        vec_t v[$];
        v.push_back(mk(0,0,0,0,0,   1,1,0,7,1,1,  0, 3'b010, s4(0,0,0,0)));
        v.push_back(mk(1,7,0,10,0,  0,0,0,0,0,0,  0, 3'b001, s4(0,0,0,0)));
        v.push_back(mk(1,7,0,10,0,  0,0,0,0,0,0,  0, 3'b100, s4(4,0,0,0)));
        foreach (v[i]) begin
            apply(v[i]); #1;
            checks++;
            if (ctl_now() !== v[i].ctl) begin
                errors++; $display("FAIL load_use[%0d] ctl got %b exp %b", i, ctl_now(), v[i].ctl);
            end
            sb.push_back(v[i].sel);
            @(posedge clk); #1;
            exp_sel = sb.pop_front();
            checks++;
            if (dut_sel() !== exp_sel) begin
                errors++; $display("FAIL load_use[%0d] sel got %h exp %h", i, dut_sel(), exp_sel);
            end
        end
    endtask

    task automatic test_split();
        vec_t v[$];
        v.push_back(mk(1,1,2,3,1,   1,4,3,0,0,0,  0, 3'b101, s4(0,0,0,0)));
        v.push_back(mk(1,1,2,3,1,   1,4,3,0,0,0,  0, 3'b010, s4(0,0,0,1)));
        v.push_back(mk(1,3,0,10,0,  1,3,0,0,0,0,  0, 3'b110, s4(3,0,3,0)));
        // load-use outranks the split, then the split proceeds
        v.push_back(mk(0,0,0,0,0,   1,0,0,15,1,1, 0, 3'b010, s4(0,0,0,0)));
        v.push_back(mk(1,0,0,16,1,  1,16,15,0,0,0, 0, 3'b001, s4(0,0,0,0)));
        v.push_back(mk(1,0,0,16,1,  1,16,15,0,0,0, 0, 3'b101, s4(0,0,0,0)));
        v.push_back(mk(1,0,0,16,1,  1,16,15,0,0,0, 0, 3'b010, s4(0,0,1,6)));
        foreach (v[i]) begin
            apply(v[i]); #1;
            checks++;
            if (ctl_now() !== v[i].ctl) begin
                errors++; $display("FAIL split[%0d] ctl got %b exp %b", i, ctl_now(), v[i].ctl);
            end
            sb.push_back(v[i].sel);
            @(posedge clk); #1;
            exp_sel = sb.pop_front();
            checks++;
            if (dut_sel() !== exp_sel) begin
                errors++; $display("FAIL split[%0d] sel got %h exp %h", i, dut_sel(), exp_sel);
            end
        end
    endtask

    task automatic test_waw_x0();
        vec_t v[$];
        v.push_back(mk(1,1,2,9,1,   1,1,2,9,1,0,  0, 3'b110, s4(0,0,0,0)));
        v.push_back(mk(1,9,0,10,0,  1,0,9,0,0,0,  0, 3'b110, s4(2,0,0,2)));
        v.push_back(mk(1,0,0,0,1,   0,0,0,0,0,0,  0, 3'b100, s4(0,0,0,0)));
        v.push_back(mk(1,0,0,0,1,   1,0,0,0,0,0,  0, 3'b110, s4(0,0,0,0)));
        foreach (v[i]) begin
            apply(v[i]); #1;
            checks++;
            if (ctl_now() !== v[i].ctl) begin
                errors++; $display("FAIL waw_x0[%0d] ctl got %b exp %b", i, ctl_now(), v[i].ctl);
            end
            sb.push_back(v[i].sel);
            @(posedge clk); #1;
            exp_sel = sb.pop_front();
            checks++;
            if (dut_sel() !== exp_sel) begin
                errors++; $display("FAIL waw_x0[%0d] sel got %h exp %h", i, dut_sel(), exp_sel);
            end
        end
    endtask

    task automatic test_flush();
        vec_t v[$];
        v.push_back(mk(0,0,0,0,0,   1,0,0,11,1,1, 0, 3'b010, s4(0,0,0,0)));
        v.push_back(mk(1,11,0,10,0, 0,0,0,0,0,0,  0, 3'b001, s4(0,0,0,0)));
        v.push_back(mk(1,11,0,10,0, 0,0,0,0,0,0,  1, 3'b000, s4(0,0,0,0)));
        v.push_back(mk(1,11,0,10,0, 0,0,0,0,0,0,  0, 3'b100, s4(6,0,0,0)));
        v.push_back(mk(1,0,0,12,1,  1,12,0,0,0,0, 0, 3'b101, s4(0,0,0,0)));
        v.push_back(mk(1,0,0,12,1,  1,12,0,0,0,0, 1, 3'b000, s4(0,0,0,0)));
        v.push_back(mk(1,12,0,10,0, 0,0,0,0,0,0,  0, 3'b100, s4(3,0,0,0)));
        foreach (v[i]) begin
            apply(v[i]); #1;
            checks++;
            if (ctl_now() !== v[i].ctl) begin
                errors++; $display("FAIL flush[%0d] ctl got %b exp %b", i, ctl_now(), v[i].ctl);
            end
            sb.push_back(v[i].sel);
            @(posedge clk); #1;
            exp_sel = sb.pop_front();
            checks++;
            if (dut_sel() !== exp_sel) begin
                errors++; $display("FAIL flush[%0d] sel got %h exp %h", i, dut_sel(), exp_sel);
            end
        end
    endtask

    task automatic test_reset_mid_split();
        vec_t v[$];
        vec_t rd_after;
        v.push_back(mk(1,0,0,14,1,  0,0,0,0,0,0,  0, 3'b100, s4(0,0,0,0)));
        v.push_back(mk(1,14,0,13,1, 1,0,13,0,0,0, 0, 3'b101, s4(1,0,0,0)));
        foreach (v[i]) begin
            apply(v[i]); #1;
            checks++;
            if (ctl_now() !== v[i].ctl) begin
                errors++; $display("FAIL rst_split[%0d] ctl got %b exp %b", i, ctl_now(), v[i].ctl);
            end
            sb.push_back(v[i].sel);
            @(posedge clk); #1;
            exp_sel = sb.pop_front();
            checks++;
            if (dut_sel() !== exp_sel) begin
                errors++; $display("FAIL rst_split[%0d] sel got %h exp %h", i, dut_sel(), exp_sel);
            end
        end
        // now in SPLIT with a live select; reset must clear it without a clock edge
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut_sel() !== 12'h000) begin
            errors++; $display("FAIL rst_split_async sel got %h exp %h", dut_sel(), 12'h000);
        end
        checks++;
        if (ctl_now() !== 3'b101) begin
            errors++; $display("FAIL rst_split_state ctl got %b exp %b", ctl_now(), 3'b101);
        end
        rd_after = mk(1,13,14,10,0, 0,0,0,0,0,0, 0, 3'b100, s4(0,0,0,0));
        apply(rd_after);
        @(negedge clk) rst_n = 1'b1;
        #1;
        checks++;
        if (ctl_now() !== rd_after.ctl) begin
            errors++; $display("FAIL rst_stale ctl got %b exp %b", ctl_now(), rd_after.ctl);
        end
        sb.push_back(rd_after.sel);
        @(posedge clk); #1;
        exp_sel = sb.pop_front();
        checks++;
        if (dut_sel() !== exp_sel) begin
            errors++; $display("FAIL rst_stale sel got %h exp %h", dut_sel(), exp_sel);
        end
    endtask

    initial begin
        test_reset();
        test_fwd_distance();
        test_load_use();
        test_split();
        test_waw_x0();
        test_flush();
        test_reset_mid_split();
        apply(mk(0,0,0,0,0, 0,0,0,0,0,0, 0, 3'b000, '0));
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Issue/hazard controller for the dual-issue pipe: slot 0 is the branch pipe (older), slot 1 is the memory pipe (younger).
- Tracks destination registers of in-flight instructions in its own shadow ID/EX, EX/MEM and MEM/WB records.
- Compares each decode-stage source against those records and registers the 3-bit forwarding-mux select for every operand, so the select is valid when that instruction sits in EX.
- Detects load-use hazards and intra-bundle RAW hazards, and sequences stalls and bundle splits.

Parameters:
REG_AW, 5, architectural register index width
SEL_W, 3, forwarding select width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
id_valid_b, id_valid_m  in  1 each  decode slot valid (branch / memory pipe)
id_rs1_b, id_rs2_b, id_rs1_m, id_rs2_m  in  REG_AW each  decode sources
id_rd_b, id_rd_m  in  REG_AW each  decode destinations
id_we_b, id_we_m  in  1 each  decode writes rd
id_is_load_m  in  1  memory-slot instruction is a load
flush  in  1  kill decode bundle this cycle
issue_b, issue_m  out  1 each  slot enters ID/EX this cycle (combinational)
stall_fetch  out  1  hold PC and IF/ID (combinational)
fwd_sel_rs1_b, fwd_sel_rs2_b, fwd_sel_rs1_m, fwd_sel_rs2_m  out  SEL_W each  registered mux selects for the instruction now in EX

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous, active-low.
- Reset state: all fwd_sel = 000, FSM = RUN, all shadow records invalid. Issue outputs and stall_fetch then follow from the decode inputs, with no hazard possible.
- Shadow records:
  - Each pipe has three records (IDEX, EXMEM, MEMWB) of {valid, rd, we, is_load}; branch-pipe is_load is always 0.
  - Every cycle: MEMWB <= EXMEM, EXMEM <= IDEX, IDEX <= issued slot info; a slot not issued is recorded as invalid (bubble).
- Match rule: src matches a record iff valid & we & rd == src & src != 0. x0 never forwards.
- Select codes: 000 normal, 001 Branch_Execute, 010 Memory_Execute, 011 Branch_Memory, 100 Memory_Memory, 101 Branch_WB, 110 Memory_WB. Code 111 is never produced.
- Select priority, youngest first: IDEX_m (010), IDEX_b (001), EXMEM_m (100), EXMEM_b (011), MEMWB_m (110), MEMWB_b (101), else 000.
- Select register: selects are registered at the decode-to-EX edge. A slot not issued registers 000.
- Load-use hazard: any valid decode source matches IDEX_m with is_load=1. Response:
  - issue_b = issue_m = 0, stall_fetch = 1, bubble into IDEX.
  - Exactly one stall cycle; next cycle the load sits in EXMEM and forwards as 100.
- Intra-bundle hazard: both slots valid, and rs1_m or rs2_m matches id_rd_b with id_we_b=1.
- FSM, 2 states:
  - RUN, no hazard: issue both valid slots, stall_fetch = 0.
  - RUN, intra-bundle hazard and no load-use: issue_b = 1, issue_m = 0, stall_fetch = 1, go to SPLIT.
  - SPLIT: branch slot is treated as already issued (masked). Issue memory slot only, then stall_fetch = 0 and go to RUN. The memory-slot source then matches IDEX_b and selects 001.
  - SPLIT, load-use on the memory slot: stay in SPLIT with stall_fetch = 1.
- Priority: load-use stall is checked before split. While stalling, the FSM state is held.
- flush (synchronous): issue_b = issue_m = 0, stall_fetch = 0, FSM -> RUN, the IDEX entry becomes a bubble. Older records (EXMEM, MEMWB) still shift normally. Flush overrides all stall and split logic.
- WAW within a bundle (same rd in both slots): no stall. Priority ordering lets the memory slot win for later consumers.
- Invalid slots never match and never cause hazards.
- Reset asserted mid-split or mid-stall: records cleared immediately, FSM -> RUN.

Decomposition:
- Shared package (Header_File.svh): SEL_W, REG_AW, fwd_sel_e enum of the seven select codes, and typedef struct inflight_t {valid, rd, we, is_load}.
- One natural sub-module, fwd_src_match. It is combinational, takes one source plus six inflight_t records, returns a fwd_sel_e and a load_hit flag, and is instantiated four times.

Test Plan:
- Slot-b ADD x5 issued, next bundle slot-b reads rs1=x5 -> next cycle fwd_sel_rs1_b = 001. One bundle later a reader sees 011; two bundles later it sees 101.
- Slot-m LW x7, next bundle slot-b reads x7 -> stall_fetch = 1, issues 0 for one cycle, then issue_b = 1 with fwd_sel_rs1_b = 100.
- Bundle {b: ADD x3, m: SW rs2=x3} -> cycle 1: issue_b = 1, issue_m = 0, stall_fetch = 1. Cycle 2: issue_m = 1, fwd_sel_rs2_m = 001, FSM back to RUN.
- Slot-b and slot-m of one bundle both write x9, consumer reads x9 next bundle -> select 010 (memory slot wins). Source x0 matching a writer of x0 -> 000.
- flush asserted during a load-use stall -> issue outputs = 0, stall_fetch = 0, FSM = RUN, next registered selects = 000.
- rst_n pulled low mid-SPLIT -> all fwd_sel = 000 asynchronously. After release, a stale producer rd no longer forwards.
